nw_align_engine: RTL and testbench

//  Parametrised Needleman-Wunsch aligner: rectangular LEN1 x LEN2 systolic score grid, runtime-programmable

---
 rtl/nw_align_engine.sv | 156 +++++++++++++++
 tb/tb_nw_align_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nw_align_engine.sv
// nw_align_engine: Needleman-Wunsch LEN1 x LEN2 wavefront score grid with latched weights
// and a valid/ready traceback stream from the corner cell back out of the grid.
module nw_align_engine #(
    parameter int LEN1       = 8,
    parameter int LEN2       = 8,
    parameter int CWIDTH     = 2,
    parameter int SWIDTH     = 16,
    parameter int CORD_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN1*CWIDTH-1:0]   s1,
    input  logic [LEN2*CWIDTH-1:0]   s2,
    input  logic signed [SWIDTH-1:0] match_w,
    input  logic signed [SWIDTH-1:0] mismatch_w,
    input  logic signed [SWIDTH-1:0] indel_w,
    output logic                     busy,
    output logic signed [SWIDTH-1:0] score,
    output logic                     score_valid,
    output logic                     tb_valid,
    input  logic                     tb_ready,
    output logic [CORD_WIDTH-1:0]    tb_x,
    output logic [CORD_WIDTH-1:0]    tb_y,
    output logic [1:0]               tb_dir,
    output logic                     tb_last,
    output logic                     done
);
    localparam int YW = LEN1 > 1 ? $clog2(LEN1) : 1;
    localparam int XW = LEN2 > 1 ? $clog2(LEN2) : 1;

    typedef enum logic [1:0] {IDLE, FILL, TRACE, DONE} state_t;
    state_t st, st_nx;

    logic [LEN1*CWIDTH-1:0]   s1_r;
    logic [LEN2*CWIDTH-1:0]   s2_r;
    logic signed [SWIDTH-1:0] mat_r, mis_r, ind_r;
    logic signed [SWIDTH-1:0] h   [LEN1][LEN2];
    logic [1:0]               dir [LEN1][LEN2];
    logic                     v   [LEN1][LEN2];
    logic signed [SWIDTH-1:0] hp  [LEN1+1][LEN2+1];
    logic                     vp  [LEN1+1][LEN2+1];
    logic signed [SWIDTH-1:0] nh  [LEN1][LEN2];
    logic [1:0]               nd  [LEN1][LEN2];
    logic                     rdy [LEN1][LEN2];
    logic signed [SWIDTH-1:0] ca, cl, cc;
    logic [YW-1:0]            py;
    logic [XW-1:0]            px;
    logic [1:0]               cur_dir;
    logic                     xfer;

    // Padded view: row 0 / column 0 hold the gap-penalty boundary, always valid.
    always_comb begin
        hp[0][0] = '0;
        vp[0][0] = 1'b1;
        for (int x = 0; x < LEN2; x++) begin
            hp[0][x+1] = hp[0][x] + ind_r;
            vp[0][x+1] = 1'b1;
        end
        for (int y = 0; y < LEN1; y++) begin
            hp[y+1][0] = hp[y][0] + ind_r;
            vp[y+1][0] = 1'b1;
            for (int x = 0; x < LEN2; x++) begin
                hp[y+1][x+1] = h[y][x];
                vp[y+1][x+1] = v[y][x];
            end
        end
    end

    always_comb begin
        ca = '0;
        cl = '0;
        cc = '0;
        for (int y = 0; y < LEN1; y++) begin
            for (int x = 0; x < LEN2; x++) begin
                ca = hp[y][x+1] + ind_r;
                cl = hp[y+1][x] + ind_r;
                cc = hp[y][x] + ((s1_r[(LEN1-1-y)*CWIDTH +: CWIDTH] == s2_r[(LEN2-1-x)*CWIDTH +: CWIDTH]) ? mat_r : mis_r);
                nd[y][x]  = (cc >= ca && cc >= cl) ? 2'b10 : (ca >= cl) ? 2'b00 : 2'b01;
                nh[y][x]  = (cc >= ca && cc >= cl) ? cc : (ca >= cl) ? ca : cl;
                rdy[y][x] = vp[y][x] & vp[y][x+1] & vp[y+1][x];
            end
        end
    end

    always_comb begin
        cur_dir  = dir[py][px];
        tb_valid = st == TRACE;
        xfer     = tb_valid & tb_ready;
        tb_x     = tb_valid ? CORD_WIDTH'(px) : '0;
        tb_y     = tb_valid ? CORD_WIDTH'(py) : '0;
        tb_dir   = tb_valid ? cur_dir : 2'b00;
        tb_last  = tb_valid && ((py == '0 && cur_dir != 2'b01) || (px == '0 && cur_dir != 2'b00));
        busy     = st != IDLE;
        done     = st == DONE;
        st_nx    = st == IDLE  ? (start ? FILL : IDLE) :
                   st == FILL  ? (v[LEN1-1][LEN2-1] ? TRACE : FILL) :
                   st == TRACE ? ((xfer && tb_last) ? DONE : TRACE) : IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) st <= IDLE;
        else        st <= st_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r        <= '0;
            s2_r        <= '0;
            mat_r       <= '0;
            mis_r       <= '0;
            ind_r       <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            px          <= '0;
            py          <= '0;
            for (int y = 0; y < LEN1; y++)
                for (int x = 0; x < LEN2; x++) begin
                    h[y][x]   <= '0;
                    dir[y][x] <= 2'b00;
                    v[y][x]   <= 1'b0;
                end
        end else begin
            if (st == IDLE && start) begin
                s1_r        <= s1;
                s2_r        <= s2;
                mat_r       <= match_w;
                mis_r       <= mismatch_w;
                ind_r       <= indel_w;
                score       <= '0;
                score_valid <= 1'b0;
                for (int y = 0; y < LEN1; y++)
                    for (int x = 0; x < LEN2; x++)
                        v[y][x] <= 1'b0;
            end
            if (st == FILL) begin
                for (int y = 0; y < LEN1; y++)
                    for (int x = 0; x < LEN2; x++)
                        if (rdy[y][x]) begin
                            h[y][x]   <= nh[y][x];
                            dir[y][x] <= nd[y][x];
                            v[y][x]   <= 1'b1;
                        end
                if (v[LEN1-1][LEN2-1]) begin
                    score       <= h[LEN1-1][LEN2-1];
                    score_valid <= 1'b1;
                    px          <= XW'(LEN2-1);
                    py          <= YW'(LEN1-1);
                end
            end
            if (xfer) begin
                px <= cur_dir == 2'b00 ? px : px - 1'b1;
                py <= cur_dir == 2'b01 ? py : py - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nw_align_engine.sv
// tb_nw_align_engine: runs a 4x4 and a 2x4 aligner side by side against a plain NW score/traceback model.
module tb_nw_align_engine;
    logic clk = 0, reset = 0, start = 0, tb_ready = 0;
    logic [7:0] s1 = 0, s2 = 0;
    logic [3:0] s1b = 0;
    logic signed [15:0] mw = 0, mmw = 0, iw = 0;
    logic busy_a, sv_a, tv_a, tl_a, dn_a, busy_b, sv_b, tv_b, tl_b, dn_b;
    logic signed [15:0] score_a, score_b;
    logic [7:0] tx_a, ty_a, tx_b, ty_b;
    logic [1:0] td_a, td_b;
    int checks = 0, failures = 0;
    int exp_a[$], exp_b[$];
    int sc_a, sc_b;
    int phase[2];

    always #5 clk = ~clk;

    nw_align_engine #(.LEN1(4), .LEN2(4), .CWIDTH(2), .SWIDTH(16), .CORD_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .match_w(mw), .mismatch_w(mmw), .indel_w(iw),
        .busy(busy_a), .score(score_a), .score_valid(sv_a),
        .tb_valid(tv_a), .tb_ready(tb_ready), .tb_x(tx_a), .tb_y(ty_a),
        .tb_dir(td_a), .tb_last(tl_a), .done(dn_a));

    nw_align_engine #(.LEN1(2), .LEN2(4), .CWIDTH(2), .SWIDTH(16), .CORD_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .start(start), .s1(s1b), .s2(s2),
        .match_w(mw), .mismatch_w(mmw), .indel_w(iw),
        .busy(busy_b), .score(score_b), .score_valid(sv_b),
        .tb_valid(tv_b), .tb_ready(tb_ready), .tb_x(tx_b), .tb_y(ty_b),
        .tb_dir(td_b), .tb_last(tl_b), .done(dn_b));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Full score matrix with the gap boundary, then walk back from the corner.
    task automatic model(input int id, input int l1, input int l2, input int a, input int b,
                         input int m, input int mm, input int g, output int sc);
        int hm[5][5];
        int dm[4][4];
        int x, y, d, last, ca, cl, cc;
        hm[0][0] = 0;
        for (int i = 0; i < l2; i++) hm[0][i+1] = (i + 1) * g;
        for (int j = 0; j < l1; j++) hm[j+1][0] = (j + 1) * g;
        for (int j = 0; j < l1; j++)
            for (int i = 0; i < l2; i++) begin
                ca = hm[j][i+1] + g;
                cl = hm[j+1][i] + g;
                cc = hm[j][i] + ((((a >> (2*(l1-1-j))) & 3) == ((b >> (2*(l2-1-i))) & 3)) ? m : mm);
                if (cc >= ca && cc >= cl) begin hm[j+1][i+1] = cc; dm[j][i] = 2; end
                else if (ca >= cl)        begin hm[j+1][i+1] = ca; dm[j][i] = 0; end
                else                      begin hm[j+1][i+1] = cl; dm[j][i] = 1; end
            end
        sc = hm[l1][l2];
        x = l2 - 1;
        y = l1 - 1;
        for (int n = 0; n < 16; n++) begin
            d = dm[y][x];
            last = ((y == 0 && d != 1) || (x == 0 && d != 0)) ? 1 : 0;
            if (id == 0) exp_a.push_back(x*1000 + y*100 + d*10 + last);
            else         exp_b.push_back(x*1000 + y*100 + d*10 + last);
            if (last == 1) break;
            if (d != 1) y--;
            if (d != 0) x--;
        end
    endtask

    task automatic step(input int id, input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] d, input logic l, input logic dn, input logic bz);
        int e;
        if (phase[id] == 0) begin
            if (v) begin
                if ((id == 0 ? exp_a.size() : exp_b.size()) == 0) begin
                    chk(id == 0 ? "extra_beat_a" : "extra_beat_b", 1, 0);
                    phase[id] = 3;
                end else begin
                    e = id == 0 ? exp_a[0] : exp_b[0];
                    chk(id == 0 ? "beat_a" : "beat_b", int'(x)*1000 + int'(y)*100 + int'(d)*10 + int'(l), e);
                    if (tb_ready) begin
                        if (id == 0) void'(exp_a.pop_front());
                        else         void'(exp_b.pop_front());
                        if (l) phase[id] = 1;
                    end
                end
            end
        end else if (phase[id] == 1) begin
            chk(id == 0 ? "done_a" : "done_b", dn, 1);
            chk(id == 0 ? "tv_off_a" : "tv_off_b", v, 0);
            phase[id] = 2;
        end else if (phase[id] == 2) begin
            chk(id == 0 ? "done_end_a" : "done_end_b", dn, 0);
            chk(id == 0 ? "idle_a" : "idle_b", bz, 0);
            phase[id] = 3;
        end
    endtask

    // mode: 0 plain, 1 stall first beats, 2 reset at E0+3, 3 disturb inputs/start after E0
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ab,
                       input int m, input int mm, input int g, input int mode);
        exp_a.delete();
        exp_b.delete();
        model(0, 4, 4, a, b, m, mm, g, sc_a);
        model(1, 2, 4, ab, b, m, mm, g, sc_b);
        @(negedge clk);
        s1 = a; s2 = b; s1b = ab; mw = 16'(m); mmw = 16'(mm); iw = 16'(g);
        start = 1; tb_ready = 0;
        @(posedge clk); #1 start = 0;
        chk("busy_start", busy_a, 1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (mode == 2 && k == 3) begin
                reset = 0;
                #1;
                chk("rst_busy", busy_a | busy_b, 0);
                chk("rst_sv", sv_a | sv_b, 0);
                chk("rst_tv", tv_a | tv_b, 0);
                chk("rst_done", dn_a | dn_b, 0);
                chk("rst_score", score_a, 0);
                @(negedge clk) reset = 1;
                return;
            end
            if (mode == 3 && k == 1) begin
                s1 = ~a; s1b = ~ab; mw = 16'(m + 2); iw = 16'(g - 1); start = 1;
            end
            if (mode == 3 && k == 2) start = 0;
            chk("sv_a_time", sv_a, k >= 8 ? 1 : 0);
            chk("sv_b_time", sv_b, k >= 6 ? 1 : 0);
            if (k == 8) chk("score_a", $signed(score_a), sc_a);
            if (k == 6) chk("score_b", $signed(score_b), sc_b);
        end
        phase[0] = 0;
        phase[1] = 0;
        for (int c = 0; c < 100 && (phase[0] != 3 || phase[1] != 3); c++) begin
            @(negedge clk);
            tb_ready = (mode == 1 && c < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (mode == 1 && c < 5) chk("stall_tv", tv_a, 1);
            step(0, tv_a, tx_a, ty_a, td_a, tl_a, dn_a, busy_a);
            step(1, tv_b, tx_b, ty_b, td_b, tl_b, dn_b, busy_b);
        end
        chk("trace_complete", phase[0] + phase[1], 6);
        chk("beats_left_a", exp_a.size(), 0);
        chk("beats_left_b", exp_b.size(), 0);
        chk("score_hold_a", $signed(score_a), sc_a);
        chk("sv_hold_a", sv_a, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy_a, 0);
        chk("reset_sv", sv_a, 0);
        chk("reset_tv", tv_a, 0);
        chk("reset_done", dn_a, 0);
        chk("reset_x", tx_a, 0);
        @(negedge clk) reset = 1;
        run(8'h1B, 8'h1B, 4'h1, 1, -1, -1, 0);
        chk("case1_score", $signed(score_a), 4);
        chk("case3_score", $signed(score_b), 0);
        run(8'h00, 8'hFF, 4'h0, 1, -1, -1, 0);
        chk("case2_score", $signed(score_a), -4);
        run(8'h1B, 8'h1B, 4'h1, 1, -1, -1, 1);
        run(8'h1B, 8'h1B, 4'h1, 1, -1, -1, 2);
        run(8'h1B, 8'h1B, 4'h1, 1, -1, -1, 0);
        chk("after_reset_score", $signed(score_a), 4);
        run(8'h1B, 8'h1B, 4'h1, 1, -1, -1, 3);
        chk("disturb_score", $signed(score_a), 4);
        for (int r = 0; r < 12; r++)
            run(8'($urandom), 8'($urandom), 4'($urandom),
                int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
                int'($urandom_range(0, 6)) - 3, r % 4 == 3 ? 1 : 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
